// File: rtl/mcu_timer_pkg.sv
// Shared types and register map for the
// parametrised MCU timer/counter.
package mcu_timer_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    RELOAD  = 2'd1,
    ONESHOT = 2'd2
  } timer_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_RELOAD   = 2'd1;
  localparam logic [1:0] ADDR_COMPARE  = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IRQ_CLR = 3;

  // Reserved encoding 11 falls back to FREE.
  function automatic timer_mode_e decode_mode(
    input logic [1:0] m
  );
    timer_mode_e r;
    unique case (m)
      2'b01:   r = RELOAD;
      2'b10:   r = ONESHOT;
      default: r = FREE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcu_timer_prescaler.sv
// Clock divider: one tick every divisor+1
// cycles while run is high.
module mcu_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] ps_q, ps_d;

  assign tick_o = run_i && (ps_q == div_i);

  always_comb begin
    ps_d = ps_q;
    if (clear_i)
      ps_d = '0;
    else if (run_i)
      ps_d = tick_o ? '0 : ps_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

endmodule

// File: rtl/mcu_timer.sv
// Timer/counter with FREE/RELOAD/ONESHOT
// modes, PWM compare and sticky irq.
module mcu_timer
  import mcu_timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cnt_o,
  output logic             irq_o,
  output logic             pwm_o,
  output logic             busy_o
);

  timer_state_e          state_q, state_d;
  timer_mode_e           mode_q, mode_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [WIDTH-1:0]      cmp_q, cmp_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  irq_q, irq_d;
  logic                  pwm_q, pwm_d;
  logic                  irq_set;
  logic                  tick;
  logic                  ctrl_wr;
  logic                  presc_wr;
  logic [3:0]            ctrl_wd;
  logic [PRESCALE_W-1:0] presc_wd;

  // Narrow configurations zero-extend write data.
  if (WIDTH >= 4) begin : g_ctrl_w
    assign ctrl_wd = cfg_wdata[3:0];
  end else begin : g_ctrl_n
    assign ctrl_wd = {{(4-WIDTH){1'b0}}, cfg_wdata};
  end

  if (PRESCALE_W <= WIDTH) begin : g_ps_w
    assign presc_wd = cfg_wdata[PRESCALE_W-1:0];
  end else begin : g_ps_n
    assign presc_wd = {{(PRESCALE_W-WIDTH){1'b0}}, cfg_wdata};
  end

  assign ctrl_wr  = cfg_we && (cfg_addr == ADDR_CTRL);
  assign presc_wr = cfg_we && (cfg_addr == ADDR_PRESCALE);

  mcu_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (state_q == RUN),
    .clear_i (ctrl_wr || presc_wr),
    .div_i   (presc_q),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_wr)
      state_d = ctrl_wd[CTRL_EN] ? RUN : IDLE;
    else if (tick && mode_q == ONESHOT && cnt_q == '0)
      state_d = DONE;
  end

  always_comb begin
    busy_o = (state_q == RUN);
  end

  always_comb begin
    reload_d = reload_q;
    cmp_d    = cmp_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    irq_set  = 1'b0;
    if (cfg_we) begin
      unique case (cfg_addr)
        ADDR_RELOAD:   reload_d = cfg_wdata;
        ADDR_COMPARE:  cmp_d    = cfg_wdata;
        ADDR_PRESCALE: presc_d  = presc_wd;
        default:
          mode_d = decode_mode(ctrl_wd[CTRL_MODE_HI:CTRL_MODE_LO]);
      endcase
    end
    if (tick) begin
      unique case (mode_q)
        RELOAD: begin
          irq_set = (cnt_q == '0);
          cnt_d   = irq_set ? reload_q : cnt_q - WIDTH'(1);
        end
        ONESHOT: begin
          irq_set = (cnt_q == '0);
          cnt_d   = irq_set ? cnt_q : cnt_q - WIDTH'(1);
        end
        default: begin
          irq_set = (cnt_q == '1);
          cnt_d   = cnt_q + WIDTH'(1);
        end
      endcase
    end
    // A restart overrides the tick update but not its irq.
    if (ctrl_wr && ctrl_wd[CTRL_EN])
      cnt_d = (mode_d == FREE) ? '0 : reload_q;
    irq_d = irq_q;
    if (ctrl_wr && ctrl_wd[CTRL_IRQ_CLR]) irq_d = 1'b0;
    if (irq_set)                          irq_d = 1'b1;
    pwm_d = (state_d == RUN) && (cnt_d < cmp_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= FREE;
      cnt_q    <= '0;
      reload_q <= '0;
      cmp_q    <= '0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      cmp_q    <= cmp_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
      pwm_q    <= pwm_d;
    end
  end

  assign cnt_o = cnt_q;
  assign irq_o = irq_q;
  assign pwm_o = pwm_q;

endmodule
